// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store funct3 encodings and the MEM-stage FSM states.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage and the data memory.
interface mem_stage_if #(parameter int XLEN = 32);

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ready
    );

endinterface

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and lane selection/extension for loads, plus
// alignment and funct3 legality checking. Purely combinational.
module load_store_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_load,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic            fault
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{offset, 3'b000} +: 8];
    assign half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        fault     = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_SB: begin
                    be    = 4'b0001 << offset;
                    wdata = {(XLEN/8){store_data[7:0]}};
                end
                F3_SH: begin
                    be    = offset[1] ? 4'b1100 : 4'b0011;
                    wdata = {(XLEN/16){store_data[15:0]}};
                    fault = offset[0];
                end
                F3_SW:   fault = |offset;
                default: fault = 1'b1;
            endcase
        end else if (is_load) begin
            case (funct3)
                F3_LB:   load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
                F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_lane};
                F3_LH: begin
                    load_data = {{(XLEN-16){half_lane[15]}}, half_lane};
                    fault     = offset[0];
                end
                F3_LHU: begin
                    load_data = {{(XLEN-16){1'b0}}, half_lane};
                    fault     = offset[0];
                end
                F3_LW:   fault = |offset;
                default: fault = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// RISC-V MEM pipeline stage: issues data-memory accesses, stalls on a slow memory,
// and fills the MEM/WB register with ALU results, load data, bubbles or exceptions.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    mem_stage_if.master     dmem,
    output logic            mem_stall,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic [XLEN-1:0] writeback_data,
    output logic            mem_exc
);

    mem_state_e      state, state_next;
    logic            is_load, is_store, both_ops;
    logic            lane_fault, fault, access, req;
    logic [XLEN-1:0] load_data;

    assign is_load  = ex_valid & ex_mem_read & ~ex_mem_write;
    assign is_store = ex_valid & ex_mem_write & ~ex_mem_read;
    assign both_ops = ex_valid & ex_mem_read & ex_mem_write;

    load_store_align #(.XLEN(XLEN)) u_align (
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (ex_funct3),
        .offset     (ex_alu_result[1:0]),
        .store_data (ex_store_data),
        .rdata      (dmem.dmem_rdata),
        .be         (dmem.dmem_be),
        .wdata      (dmem.dmem_wdata),
        .load_data  (load_data),
        .fault      (lane_fault)
    );

    assign fault  = both_ops | ((is_load | is_store) & lane_fault);
    assign access = (is_load | is_store) & ~lane_fault;

    // The EX/MEM slot is frozen while stalled, so the request fields stay stable in WAIT.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        case (state)
            ST_IDLE: begin
                req = access;
                if (access && !dmem.dmem_ready) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                req = 1'b1;
                if (dmem.dmem_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (reset) req = 1'b0;
    end

    assign dmem.dmem_req  = req;
    assign dmem.dmem_we   = is_store;
    assign dmem.dmem_addr = {ex_alu_result[XLEN-1:2], 2'b00};
    assign mem_stall      = req & ~dmem.dmem_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset || mem_stall) begin
            wb_valid       <= 1'b0;
            wb_rd          <= '0;
            wb_reg_write   <= 1'b0;
            writeback_data <= '0;
            mem_exc        <= 1'b0;
        end else begin
            wb_valid       <= ex_valid;
            wb_rd          <= ex_rd;
            wb_reg_write   <= ex_valid & ex_reg_write & ~ex_mem_write & ~fault & (ex_rd != 5'd0);
            writeback_data <= is_load ? load_data : ex_alu_result;
            mem_exc        <= fault;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed instruction table with a writeback scoreboard.
module tb_mem_stage;
    import riscv_pkg::*;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
        logic        exc;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        mem_stall, wb_valid, wb_reg_write, mem_exc;
    logic [4:0]  wb_rd;
    logic [31:0] writeback_data;

    wb_exp_t sb[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_if #(.XLEN(32)) bus();

    mem_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_alu_result  (ex_alu_result),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_funct3      (ex_funct3),
        .dmem           (bus),
        .mem_stall      (mem_stall),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_reg_write   (wb_reg_write),
        .writeback_data (writeback_data),
        .mem_exc        (mem_exc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic wb_exp_t mk(input logic [4:0] rd, input logic rw,
                                   input logic [31:0] data, input logic exc);
        wb_exp_t r;
        r.rd   = rd;
        r.rw   = rw;
        r.data = data;
        r.exc  = exc;
        return r;
    endfunction

    // Writeback monitor: every valid MEM/WB slot must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("wb_unexpected_sb_size", 32'(sb.size()), 32'd1);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                check("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
                check("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, e.rw});
                check("mem_exc", {31'b0, mem_exc}, {31'b0, e.exc});
                if (e.rw) check("writeback_data", writeback_data, e.data);
            end
        end
    end

    task automatic do_op(input logic mr, input logic mw, input logic rw, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                         input int wait_n, input logic [31:0] rdata, input logic exp_req,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata, input wb_exp_t e);
        logic [31:0] exp_addr;
        exp_addr = {alu[31:2], 2'b00};
        @(negedge clk);
        ex_valid       = 1'b1;
        ex_mem_read    = mr;
        ex_mem_write   = mw;
        ex_reg_write   = rw;
        ex_funct3      = f3;
        ex_alu_result  = alu;
        ex_store_data  = sd;
        ex_rd          = rd;
        bus.dmem_ready = (wait_n == 0);
        bus.dmem_rdata = rdata;
        sb.push_back(e);
        #1;
        check("dmem_req", {31'b0, bus.dmem_req}, {31'b0, exp_req});
        check("mem_stall", {31'b0, mem_stall}, {31'b0, (exp_req && wait_n > 0)});
        if (exp_req) begin
            check("dmem_addr", bus.dmem_addr, exp_addr);
            check("dmem_we", {31'b0, bus.dmem_we}, {31'b0, mw});
            check("dmem_be", {28'b0, bus.dmem_be}, {28'b0, exp_be});
            if (mw) check("dmem_wdata", bus.dmem_wdata, exp_wdata);
        end
        for (int k = 0; k < wait_n; k++) begin
            @(negedge clk);
            bus.dmem_ready = (k == wait_n - 1);
            #1;
            check("wait_stall", {31'b0, mem_stall}, {31'b0, (k != wait_n - 1)});
            check("wait_req", {31'b0, bus.dmem_req}, 32'd1);
            check("wait_addr_hold", bus.dmem_addr, exp_addr);
            check("wait_bubble", {31'b0, wb_valid}, 32'd0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ex_valid       = 1'b0;
            ex_mem_read    = 1'b0;
            ex_mem_write   = 1'b0;
            bus.dmem_ready = 1'b0;
            #1;
            check("idle_req", {31'b0, bus.dmem_req}, 32'd0);
            check("idle_stall", {31'b0, mem_stall}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a valid aligned load pending: request and stall must stay gated.
        reset          = 1'b1;
        ex_valid       = 1'b1;
        ex_mem_read    = 1'b1;
        ex_mem_write   = 1'b0;
        ex_reg_write   = 1'b1;
        ex_funct3      = F3_LW;
        ex_alu_result  = 32'h0000_0100;
        ex_store_data  = 32'h0;
        ex_rd          = 5'd1;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", {31'b0, bus.dmem_req}, 32'd0);
        check("rst_stall", {31'b0, mem_stall}, 32'd0);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        check("rst_wb_reg_write", {31'b0, wb_reg_write}, 32'd0);
        check("rst_writeback_data", writeback_data, 32'd0);
        check("rst_mem_exc", {31'b0, mem_exc}, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        ex_valid = 1'b0;

        //    mr mw rw f3      alu            sd             rd  wt rdata          req be       wdata          expected writeback
        do_op(0, 0, 1, 3'b000, 32'h0000_000F, 32'h0,         1,  0, 32'h0,         0, 4'h0,    32'h0,         mk(1, 1, 32'h0000_000F, 0));
        do_op(1, 0, 1, F3_LB,  32'h0000_0103, 32'h0,         2,  0, 32'h80FF_1234, 1, 4'hF,    32'h0,         mk(2, 1, 32'hFFFF_FF80, 0));
        do_op(1, 0, 1, F3_LBU, 32'h0000_0103, 32'h0,         3,  0, 32'h80FF_1234, 1, 4'hF,    32'h0,         mk(3, 1, 32'h0000_0080, 0));
        do_op(0, 1, 1, F3_SH,  32'h0000_0102, 32'h0000_ABCD, 5,  0, 32'h0,         1, 4'b1100, 32'hABCD_ABCD, mk(5, 0, 32'h0, 0));
        do_op(1, 0, 1, F3_LW,  32'h0000_0200, 32'h0,         6,  3, 32'hDEAD_BEEF, 1, 4'hF,    32'h0,         mk(6, 1, 32'hDEAD_BEEF, 0));
        do_op(1, 0, 1, F3_LW,  32'h0000_0202, 32'h0,         7,  0, 32'h1234_5678, 0, 4'h0,    32'h0,         mk(7, 0, 32'h0, 1));
        do_op(1, 0, 1, F3_LH,  32'h0000_0102, 32'h0,         8,  0, 32'h80FF_1234, 1, 4'hF,    32'h0,         mk(8, 1, 32'hFFFF_80FF, 0));
        do_op(1, 0, 1, F3_LHU, 32'h0000_0100, 32'h0,         9,  0, 32'h80FF_9234, 1, 4'hF,    32'h0,         mk(9, 1, 32'h0000_9234, 0));
        do_op(1, 0, 1, F3_LH,  32'h0000_0101, 32'h0,         10, 0, 32'h0,         0, 4'h0,    32'h0,         mk(10, 0, 32'h0, 1));
        do_op(0, 1, 0, F3_SB,  32'h0000_0101, 32'h1234_565A, 11, 1, 32'h0,         1, 4'b0010, 32'h5A5A_5A5A, mk(11, 0, 32'h0, 0));
        do_op(0, 1, 0, F3_SW,  32'h0000_0104, 32'hCAFE_F00D, 12, 2, 32'h0,         1, 4'hF,    32'hCAFE_F00D, mk(12, 0, 32'h0, 0));
        do_op(0, 0, 1, 3'b000, 32'h0000_0055, 32'h0,         0,  0, 32'h0,         0, 4'h0,    32'h0,         mk(0, 0, 32'h0, 0));
        do_op(1, 1, 1, F3_LW,  32'h0000_0100, 32'h0,         13, 0, 32'h0,         0, 4'h0,    32'h0,         mk(13, 0, 32'h0, 1));
        do_op(1, 0, 1, 3'b011, 32'h0000_0100, 32'h0,         14, 0, 32'h0,         0, 4'h0,    32'h0,         mk(14, 0, 32'h0, 1));
        do_op(0, 1, 0, 3'b100, 32'h0000_0100, 32'h0,         15, 0, 32'h0,         0, 4'h0,    32'h0,         mk(15, 0, 32'h0, 1));
        do_op(1, 0, 1, F3_LB,  32'h0000_0100, 32'h0,         16, 0, 32'h80FF_1234, 1, 4'hF,    32'h0,         mk(16, 1, 32'h0000_0034, 0));
        idle(2);
        check("drain_before_reset", 32'(sb.size()), 32'd0);

        // Reset arriving in the second WAIT cycle abandons the outstanding load.
        @(negedge clk);
        ex_valid       = 1'b1;
        ex_mem_read    = 1'b1;
        ex_mem_write   = 1'b0;
        ex_reg_write   = 1'b1;
        ex_funct3      = F3_LW;
        ex_alu_result  = 32'h0000_0300;
        ex_rd          = 5'd20;
        bus.dmem_ready = 1'b0;
        #1;
        check("abort_issue_stall", {31'b0, mem_stall}, 32'd1);
        @(negedge clk);
        #1;
        check("abort_wait1_stall", {31'b0, mem_stall}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_rst_req", {31'b0, bus.dmem_req}, 32'd0);
        check("abort_rst_stall", {31'b0, mem_stall}, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        ex_valid = 1'b0;
        #1;
        check("abort_after_req", {31'b0, bus.dmem_req}, 32'd0);
        check("abort_after_stall", {31'b0, mem_stall}, 32'd0);
        check("abort_after_wb_valid", {31'b0, wb_valid}, 32'd0);

        do_op(1, 0, 1, F3_LW,  32'h0000_0300, 32'h0,         17, 0, 32'h0BAD_F00D, 1, 4'hF,    32'h0,         mk(17, 1, 32'h0BAD_F00D, 0));
        idle(3);
        check("drain_final", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have ports, one clock; reset is synchronous and active-high:
  clk  input  1  rising-edge clock
  reset  input  1  synchronous, active-high
  ex_valid  input  1  EX/MEM slot holds an instruction
  ex_alu_result  input  XLEN  ALU result / effective address
  ex_store_data  input  XLEN  rs2 value for stores
  ex_rd  input  5  destination register
  ex_reg_write  input  1  instruction writes rd
  ex_mem_read  input  1  load
  ex_mem_write  input  1  store
  ex_funct3  input  3  access size/sign
  dmem_req  output  1  memory request
  dmem_we  output  1  write enable
  dmem_addr  output  XLEN  word-aligned address (bits[1:0]=0)
  dmem_wdata  output  XLEN  lane-replicated store data
  dmem_be  output  4  byte enables
  dmem_rdata  input  XLEN  read word
  dmem_ready  input  1  access completes this cycle
  mem_stall  output  1  hold EX/MEM and upstream
  wb_valid  output  1  MEM/WB slot valid
  wb_rd  output  5  destination register
  wb_reg_write  output  1  register-file write enable
  writeback_data  output  XLEN  value written to rd
  mem_exc  output  1  misaligned/illegal access flag

Function
REQ-003 SHALL use FSM IDLE/WAIT; IDLE on reset.
REQ-004 Non-memory instruction (ex_valid, neither ex_mem_read nor ex_mem_write) SHALL appear in MEM/WB one cycle later, writeback_data=ex_alu_result, no stall.
REQ-005 In IDLE, valid aligned memory op SHALL assert dmem_req combinationally the same cycle; dmem_ready the same cycle completes it (zero stall cycles).
REQ-006 If dmem_ready low, SHALL assert mem_stall, enter WAIT, hold dmem_req/we/addr/wdata/be stable until dmem_ready.
REQ-007 In WAIT, cycle with dmem_ready high SHALL deassert mem_stall, load MEM/WB, return to IDLE; no new request issued that cycle.
REQ-008 While mem_stall is high, MEM/WB SHALL load a bubble (wb_valid=0).
REQ-009 dmem_addr SHALL be {ex_alu_result[XLEN-1:2],2'b00}; byte offset = ex_alu_result[1:0].
REQ-010 Stores: SB be=0001<<off, wdata=byte x4; SH be=0011 (off 0) or 1100 (off 2), wdata=half x2; SW be=1111.
REQ-011 Loads: LB/LH sign-extend, LBU/LHU zero-extend selected lane; LW whole word; dmem_be=1111 for loads.
REQ-012 Misaligned (H with off[0]=1; W with off!=0) or illegal funct3 (load 011/110/111, store 011-111) SHALL issue no dmem_req, no stall, and produce wb_valid=1, wb_reg_write=0, mem_exc=1 for one cycle.
REQ-013 wb_reg_write SHALL be forced 0 when wb_rd=0; stores SHALL give wb_reg_write=0.
REQ-014 ex_mem_read and ex_mem_write both high SHALL be treated as illegal (REQ-012).
REQ-015 mem_exc SHALL be registered, aligned with its wb_valid slot.

Reset
REQ-016 reset high SHALL force state IDLE, wb_valid=0, wb_reg_write=0, wb_rd=0, writeback_data=0, mem_exc=0 on the next edge.
REQ-017 dmem_req and mem_stall SHALL be gated low while reset is high, including reset during WAIT; the outstanding access is abandoned.

Structure
REQ-018 Shared package riscv_pkg SHALL hold funct3 load/store encodings and the mem_stage state enum.
REQ-019 Byte-lane/extension logic SHALL live in one combinational sub-module load_store_align.
REQ-020 RTL SHALL be 120-400 lines, no latches, single clock domain.

Verification
REQ-021 ADD result 0x0000000F, rd=1, no mem op -> next cycle wb_valid=1, wb_rd=1, writeback_data=0x0000000F, mem_stall never high.
REQ-022 LB addr 0x103, dmem_rdata=0x80FF1234, dmem_ready same cycle -> dmem_addr=0x100, writeback_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-023 SH addr 0x102, store_data=0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, wb_reg_write=0.
REQ-024 LW addr 0x200, dmem_ready low 3 cycles -> mem_stall high exactly 3 cycles, dmem_addr stable, 3 bubbles, then rdata written.
REQ-025 LW addr 0x202 -> no dmem_req, mem_exc=1 one cycle, wb_reg_write=0.
REQ-026 Reset asserted in WAIT cycle 2 -> next cycle state IDLE, dmem_req=0, mem_stall=0, wb_valid=0.
